pc_increment: RTL and testbench

Next-address logic for the program counter. It sits directly upstream of reg_PCL and reg_PCH:
- It takes their loopback outputs (PCL_LOOP, PCH_LOOP) or the ADL/ADH buses as the source.
- It optionally increments the 16-bit value.
- It drives the DATA inputs that both PC registers latch on every CLK rising edge.

The PCL-to-PCH carry is registered, so PCH advances one cycle after a PCL wrap. The block also forces the reset vector address FFFC while reset is held.

---
 rtl/cpu_defs.sv | 10 +
 rtl/pc_increment_if.sv | 27 ++
 rtl/inc8.sv | 11 +
 rtl/pc_increment.sv | 69 ++++++
 tb/tb_pc_increment.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Constants shared by the program-counter datapath: reset vector and PC source encodings.
package cpu_defs;

  localparam logic [7:0] RESET_VECTOR_L = 8'hFC;
  localparam logic [7:0] RESET_VECTOR_H = 8'hFF;

  localparam logic PC_SRC_LOOP = 1'b0;
  localparam logic PC_SRC_BUS  = 1'b1;

endpackage

// File: rtl/pc_increment_if.sv
// Sequencer-facing signals of the PC next-address logic; slave is the pc_increment side.
interface pc_increment_if;

  logic       RDY;
  logic [7:0] PCL_LOOP;
  logic [7:0] PCH_LOOP;
  logic [7:0] ADL_BUS;
  logic [7:0] ADH_BUS;
  logic       PCL_SEL_ADL;
  logic       PCH_SEL_ADH;
  logic       INC_PC;
  logic [7:0] PCL_DATA;
  logic [7:0] PCH_DATA;
  logic       CARRY_PENDING;
  logic       PAGE_CROSS;

  modport master (
    output RDY, PCL_LOOP, PCH_LOOP, ADL_BUS, ADH_BUS, PCL_SEL_ADL, PCH_SEL_ADH, INC_PC,
    input  PCL_DATA, PCH_DATA, CARRY_PENDING, PAGE_CROSS
  );

  modport slave (
    input  RDY, PCL_LOOP, PCH_LOOP, ADL_BUS, ADH_BUS, PCL_SEL_ADL, PCH_SEL_ADH, INC_PC,
    output PCL_DATA, PCH_DATA, CARRY_PENDING, PAGE_CROSS
  );

endinterface

// File: rtl/inc8.sv
// 8-bit incrementer: o_out = i_in + i_cin, o_cout set on wrap.
module inc8 (
  input  logic [7:0] i_in,
  input  logic       i_cin,
  output logic [7:0] o_out,
  output logic       o_cout
);

  assign {o_cout, o_out} = {1'b0, i_in} + {8'd0, i_cin};

endmodule

// File: rtl/pc_increment.sv
// PC next-address logic: source select, optional increment, registered PCL->PCH carry.
module pc_increment
  import cpu_defs::*;
#(
  parameter logic [7:0] RESET_PCL = RESET_VECTOR_L,
  parameter logic [7:0] RESET_PCH = RESET_VECTOR_H
) (
  input logic          CLK,
  input logic          RST_N,
  pc_increment_if.slave bus
);

  logic [7:0] w_src_l;
  logic [7:0] w_src_h;
  logic [7:0] w_sum_l;
  logic [7:0] w_sum_h;
  logic       w_cout_l;
  logic       w_unused_cout_h;
  logic       r_carry;
  logic       r_page_cross;

  assign w_src_l = (bus.PCL_SEL_ADL == PC_SRC_LOOP) ? bus.PCL_LOOP : bus.ADL_BUS;
  assign w_src_h = (bus.PCH_SEL_ADH == PC_SRC_BUS)  ? bus.ADH_BUS  : bus.PCH_LOOP;

  // Low-byte carry-out is exactly INC_PC & (src_l == FF).
  inc8 u_inc_l (
    .i_in   (w_src_l),
    .i_cin  (bus.INC_PC),
    .o_out  (w_sum_l),
    .o_cout (w_cout_l)
  );

  // High byte never generates a carry further up; PC simply wraps at FFFF.
  inc8 u_inc_h (
    .i_in   (w_src_h),
    .i_cin  (r_carry),
    .o_out  (w_sum_h),
    .o_cout (w_unused_cout_h)
  );

  always_comb begin
    bus.PCL_DATA = w_sum_l;
    bus.PCH_DATA = w_sum_h;
    if (!RST_N) begin
      bus.PCL_DATA = RESET_PCL;
      bus.PCH_DATA = RESET_PCH;
    end else if (!bus.RDY) begin
      bus.PCL_DATA = bus.PCL_LOOP;
      bus.PCH_DATA = bus.PCH_LOOP;
    end
  end

  // Hold keeps the pending carry but drops the page-cross pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_carry      <= 1'b0;
      r_page_cross <= 1'b0;
    end else if (bus.RDY) begin
      r_carry      <= w_cout_l;
      r_page_cross <= w_cout_l;
    end else begin
      r_page_cross <= 1'b0;
    end
  end

  assign bus.CARRY_PENDING = r_carry;
  assign bus.PAGE_CROSS    = r_page_cross;

endmodule

// File: tb/tb_pc_increment.sv
// Directed bench for pc_increment: per-cycle vector table plus reset sequences.
module tb_pc_increment;

  typedef struct {
    logic       rdy;
    logic       sel_l;
    logic       sel_h;
    logic       inc;
    logic [7:0] pcl_loop;
    logic [7:0] pch_loop;
    logic [7:0] adl;
    logic [7:0] adh;
    logic [7:0] e_pcl;
    logic [7:0] e_pch;
    logic       e_cp;
    logic       e_pg;
  } vec_t;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  pc_increment_if u_if ();

  pc_increment dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (u_if)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic sel_l, input logic sel_h, input logic inc,
                       input logic [7:0] pcl, input logic [7:0] pch,
                       input logic [7:0] adl, input logic [7:0] adh);
    u_if.RDY         = rdy;
    u_if.PCL_SEL_ADL = sel_l;
    u_if.PCH_SEL_ADH = sel_h;
    u_if.INC_PC      = inc;
    u_if.PCL_LOOP    = pcl;
    u_if.PCH_LOOP    = pch;
    u_if.ADL_BUS     = adl;
    u_if.ADH_BUS     = adh;
  endtask

  task automatic add(input logic rdy, input logic sel_l, input logic sel_h, input logic inc,
                     input logic [7:0] pcl, input logic [7:0] pch,
                     input logic [7:0] adl, input logic [7:0] adh,
                     input logic [7:0] e_pcl, input logic [7:0] e_pch,
                     input logic e_cp, input logic e_pg);
    vec_t v;
    v = '{rdy, sel_l, sel_h, inc, pcl, pch, adl, adh, e_pcl, e_pch, e_cp, e_pg};
    vecs.push_back(v);
  endtask

  // Check all four outputs at the falling edge; state outputs reflect the previous rising edge.
  task automatic check_all(input string tag, input logic [7:0] e_pcl, input logic [7:0] e_pch,
                           input logic e_cp, input logic e_pg);
    @(negedge CLK);
    chk({tag, ".PCL_DATA"}, u_if.PCL_DATA, e_pcl);
    chk({tag, ".PCH_DATA"}, u_if.PCH_DATA, e_pch);
    chk({tag, ".CARRY_PENDING"}, {7'd0, u_if.CARRY_PENDING}, {7'd0, e_cp});
    chk({tag, ".PAGE_CROSS"}, {7'd0, u_if.PAGE_CROSS}, {7'd0, e_pg});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //   rdy sl sh inc pclL   pchL   adl    adh    ePCL   ePCH   cp    pg
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    add(1, 0, 0, 1, 8'hAA, 8'h12, 8'h00, 8'h00, 8'hAB, 8'h12, 1'b0, 1'b0);
    add(1, 0, 0, 0, 8'hAB, 8'h12, 8'h00, 8'h00, 8'hAB, 8'h12, 1'b0, 1'b0);
    add(1, 0, 0, 1, 8'hFF, 8'h12, 8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0);
    add(1, 0, 0, 1, 8'h00, 8'h12, 8'h00, 8'h00, 8'h01, 8'h13, 1'b1, 1'b1);
    add(1, 0, 0, 0, 8'h01, 8'h13, 8'h00, 8'h00, 8'h01, 8'h13, 1'b0, 1'b0);
    // Bus load, then jump+1 wrap from ADL with carry landing on the next cycle.
    add(1, 1, 1, 0, 8'h01, 8'h13, 8'hBB, 8'hC0, 8'hBB, 8'hC0, 1'b0, 1'b0);
    add(1, 1, 1, 1, 8'h01, 8'h13, 8'hFF, 8'hC0, 8'h00, 8'hC0, 1'b0, 1'b0);
    add(1, 0, 0, 0, 8'h00, 8'hC0, 8'h00, 8'h00, 8'h00, 8'hC1, 1'b1, 1'b1);
    add(1, 0, 0, 0, 8'h00, 8'hC1, 8'h00, 8'h00, 8'h00, 8'hC1, 1'b0, 1'b0);
    // Pending carry still applies when ADH is selected.
    add(1, 0, 0, 1, 8'hFF, 8'h34, 8'h00, 8'h00, 8'h00, 8'h34, 1'b0, 1'b0);
    add(1, 0, 1, 0, 8'h00, 8'h34, 8'h00, 8'h70, 8'h00, 8'h71, 1'b1, 1'b1);
    // Hold ignores selects and INC_PC.
    add(0, 1, 1, 1, 8'h45, 8'h67, 8'h99, 8'h88, 8'h45, 8'h67, 1'b0, 1'b0);
    add(1, 0, 0, 0, 8'h45, 8'h67, 8'h99, 8'h88, 8'h45, 8'h67, 1'b0, 1'b0);
    // Hold for three cycles with a carry pending.
    add(1, 0, 0, 1, 8'hFF, 8'h12, 8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0);
    add(0, 0, 0, 1, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h12, 1'b1, 1'b1);
    add(0, 0, 0, 1, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h12, 1'b1, 1'b0);
    add(0, 0, 0, 1, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h12, 1'b1, 1'b0);
    add(1, 0, 0, 0, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h13, 1'b1, 1'b0);
    add(1, 0, 0, 0, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 1'b0, 1'b0);
    // Back-to-back wraps: each pending carry consumed while a new one is generated.
    add(1, 0, 0, 1, 8'hFF, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 1'b0, 1'b0);
    add(1, 1, 0, 1, 8'h00, 8'h20, 8'hFF, 8'h00, 8'h00, 8'h21, 1'b1, 1'b1);
    add(1, 0, 0, 0, 8'h00, 8'h21, 8'h00, 8'h00, 8'h00, 8'h22, 1'b1, 1'b1);
    add(1, 0, 0, 0, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h22, 1'b0, 1'b0);

    // Reset for two cycles with increment and bus activity present.
    RST_N = 1'b0;
    drive(1, 1, 0, 1, 8'h00, 8'h00, 8'h55, 8'h00);
    @(negedge CLK);
    chk("rst0.PCL_DATA", u_if.PCL_DATA, 8'hFC);
    chk("rst0.PCH_DATA", u_if.PCH_DATA, 8'hFF);
    @(posedge CLK);
    #1;
    check_all("rst1", 8'hFC, 8'hFF, 1'b0, 1'b0);

    RST_N = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].sel_l, vecs[i].sel_h, vecs[i].inc,
            vecs[i].pcl_loop, vecs[i].pch_loop, vecs[i].adl, vecs[i].adh);
      check_all($sformatf("vec%0d", i), vecs[i].e_pcl, vecs[i].e_pch, vecs[i].e_cp,
                vecs[i].e_pg);
    end

    // Reset asserted while a carry is pending: carry discarded.
    drive(1, 0, 0, 1, 8'hFF, 8'h12, 8'h00, 8'h00);
    check_all("mid.wrap", 8'h00, 8'h12, 1'b0, 1'b0);
    RST_N = 1'b0;
    drive(1, 0, 0, 1, 8'h00, 8'h12, 8'h00, 8'h00);
    check_all("mid.rst", 8'hFC, 8'hFF, 1'b1, 1'b1);
    RST_N = 1'b1;
    drive(1, 0, 0, 0, 8'h00, 8'h12, 8'h00, 8'h00);
    check_all("mid.rel", 8'h00, 8'h12, 1'b0, 1'b0);

    // Reset beats RDY=0.
    RST_N = 1'b0;
    drive(0, 0, 0, 0, 8'h34, 8'h56, 8'h00, 8'h00);
    check_all("rst.hold", 8'hFC, 8'hFF, 1'b0, 1'b0);
    RST_N = 1'b1;
    drive(1, 0, 0, 1, 8'h34, 8'h56, 8'h00, 8'h00);
    check_all("rst.after", 8'h35, 8'h56, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
